// File: rtl/riscv32ima_pkg.sv
// Shared types and constants for the riscv32ima core slice.
// Fetch packets are an address-tagged pair of 32-bit instructions.
package riscv32ima_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 64;
  localparam int INST_WIDTH = 32;
  localparam int PKT_WIDTH  = ADDR_WIDTH + DATA_WIDTH;

  localparam logic [ADDR_WIDTH-1:0] RESET_PC = 32'h1000_0000;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } fetch_pkt_t;

  // Major opcodes shared with decode
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_AMO    = 7'b0101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

endpackage

// File: rtl/riscv32ima_pkt_fifo.sv
// DEPTH-entry synchronous FIFO of fetch packets with flush.
// Flush clears pointers and count only; storage keeps stale contents.
module riscv32ima_pkt_fifo
  import riscv32ima_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [PKT_WIDTH-1:0]   wr_pkt,
  output logic [PKT_WIDTH-1:0]   rd_pkt,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_pkt_t       mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_pkt  = mem[head];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      if (do_push) begin
        mem[tail] <= wr_pkt;
        tail      <= tail + PTR_W'(1);
      end
      if (do_pop) head <= head + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/riscv32ima_ibuf.sv
// Instruction buffer: queues 64-bit fetch packets and hands 32-bit
// instructions to decode, low half first; flush drops everything buffered.
module riscv32ima_ibuf
  import riscv32ima_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch_valid,
  output logic                   fetch_ready,
  input  logic [ADDR_WIDTH-1:0]  fetch_address,
  input  logic [DATA_WIDTH-1:0]  fetch_data,
  input  logic                   flush,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [ADDR_WIDTH-1:0]  inst_pc,
  output logic [INST_WIDTH-1:0]  inst_data,
  output logic [$clog2(DEPTH):0] count
);

  fetch_pkt_t head_pkt;
  logic       full;
  logic       empty;
  logic       push;
  logic       pop;
  logic       advance;
  logic       hi_done;
  logic       half;
  logic       unused_addr_lsb;

  riscv32ima_pkt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .flush  (flush),
    .wr_pkt ({fetch_address, fetch_data}),
    .rd_pkt (head_pkt),
    .full   (full),
    .empty  (empty),
    .count  (count)
  );

  assign fetch_ready = ~full;
  assign inst_valid  = ~empty;
  assign push        = fetch_valid & fetch_ready & ~flush;
  assign advance     = inst_valid & inst_ready & ~flush;

  // A misaligned head starts in its upper half; hi_done marks that the
  // lower half of an aligned head has already been consumed.
  assign half = ~empty & (head_pkt.addr[2] | hi_done);
  assign pop  = advance & half;

  assign inst_data = half ? head_pkt.data[63:32] : head_pkt.data[31:0];
  assign inst_pc   = {head_pkt.addr[ADDR_WIDTH-1:3], half, 2'b00};

  assign unused_addr_lsb = ^head_pkt.addr[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_done <= 1'b0;
    end else if (flush) begin
      hi_done <= 1'b0;
    end else if (advance) begin
      hi_done <= ~half;
    end
  end

endmodule

// File: tb/tb_riscv32ima_ibuf.sv
// Directed bench for riscv32ima_ibuf: alignment, backpressure, flush,
// a toggling-ready stream and asynchronous reset.
module tb_riscv32ima_ibuf;

  logic        clk;
  logic        rst;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_address;
  logic [63:0] fetch_data;
  logic        flush;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;
  logic [1:0]  count;

  int n_chk;
  int n_err;

  riscv32ima_ibuf #(.DEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .fetch_valid   (fetch_valid),
    .fetch_ready   (fetch_ready),
    .fetch_address (fetch_address),
    .fetch_data    (fetch_data),
    .flush         (flush),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_pc       (inst_pc),
    .inst_data     (inst_data),
    .count         (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_inst(input string tag, input logic [31:0] pc, input logic [31:0] data);
    chk({tag, "_valid"}, inst_valid, 1'b1);
    chk({tag, "_pc"}, inst_pc, pc);
    chk({tag, "_data"}, inst_data, data);
  endtask

  task automatic offer(input logic [31:0] addr);
    fetch_valid   = 1'b1;
    fetch_address = addr;
    fetch_data    = {addr + 32'd4, addr};
  endtask

  logic [31:0] exp_pc;
  logic [31:0] nxt;
  logic        acc;

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b1;
    fetch_valid = 1'b0;
    fetch_address = '0;
    fetch_data = '0;
    flush = 1'b0;
    inst_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", inst_valid, 1'b0);
    chk("rst_fready", fetch_ready, 1'b1);
    chk("rst_pc", inst_pc, 32'h0);
    chk("rst_data", inst_data, 32'h0);
    chk("rst_count", count, 2'd0);
    rst = 1'b0;
    tick();

    // 1: aligned packet, low half then high half
    fetch_valid   = 1'b1;
    fetch_address = 32'h1000_0000;
    fetch_data    = 64'h00500093_00000013;
    inst_ready    = 1'b1;
    chk("t1_no_bypass", inst_valid, 1'b0);
    tick();
    fetch_valid = 1'b0;
    exp_inst("t1_lo", 32'h1000_0000, 32'h0000_0013);
    chk("t1_count", count, 2'd1);
    tick();
    exp_inst("t1_hi", 32'h1000_0004, 32'h0050_0093);
    tick();
    chk("t1_empty", inst_valid, 1'b0);
    chk("t1_count0", count, 2'd0);

    // 2: misaligned packet yields only the upper half
    fetch_valid   = 1'b1;
    fetch_address = 32'h1000_0004;
    fetch_data    = 64'hAAAA_AAAA_BBBB_BBBB;
    tick();
    fetch_valid = 1'b0;
    exp_inst("t2_mis", 32'h1000_0004, 32'hAAAA_AAAA);
    tick();
    chk("t2_empty", inst_valid, 1'b0);

    // 3: backpressure, three packets offered back-to-back
    inst_ready = 1'b0;
    offer(32'h3000_0000);
    tick();
    chk("t3_count1", count, 2'd1);
    chk("t3_fready1", fetch_ready, 1'b1);
    offer(32'h3000_0008);
    tick();
    chk("t3_count2", count, 2'd2);
    chk("t3_full", fetch_ready, 1'b0);
    offer(32'h3000_0010);
    tick();
    chk("t3_held_count", count, 2'd2);
    chk("t3_held_fready", fetch_ready, 1'b0);
    inst_ready = 1'b1;
    exp_inst("t3_i0", 32'h3000_0000, 32'h3000_0000);
    tick();
    exp_inst("t3_i1", 32'h3000_0004, 32'h3000_0004);
    chk("t3_still_full", fetch_ready, 1'b0);
    tick();
    exp_inst("t3_i2", 32'h3000_0008, 32'h3000_0008);
    chk("t3_fready_back", fetch_ready, 1'b1);
    chk("t3_count_pop", count, 2'd1);
    tick();
    fetch_valid = 1'b0;
    chk("t3_count_refill", count, 2'd2);
    exp_inst("t3_i3", 32'h3000_000C, 32'h3000_000C);
    tick();
    exp_inst("t3_i4", 32'h3000_0010, 32'h3000_0010);
    tick();
    exp_inst("t3_i5", 32'h3000_0014, 32'h3000_0014);
    tick();
    chk("t3_empty", inst_valid, 1'b0);
    chk("t3_count0", count, 2'd0);

    // 4: flush with a full buffer, offered packet and ready decode
    inst_ready = 1'b0;
    offer(32'h4000_0000);
    tick();
    offer(32'h4000_0008);
    tick();
    chk("t4_count2", count, 2'd2);
    offer(32'h5000_0000);
    flush = 1'b1;
    inst_ready = 1'b1;
    tick();
    flush = 1'b0;
    fetch_valid = 1'b0;
    chk("t4_count0", count, 2'd0);
    chk("t4_valid0", inst_valid, 1'b0);
    chk("t4_fready", fetch_ready, 1'b1);
    // flush with room in the buffer: the offered push must still be dropped
    inst_ready = 1'b0;
    offer(32'h6000_0000);
    tick();
    offer(32'h7000_0000);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    fetch_valid = 1'b0;
    chk("t4_push_dropped", count, 2'd0);
    tick();
    chk("t4_still_empty", inst_valid, 1'b0);
    offer(32'h2000_0008);
    tick();
    fetch_valid = 1'b0;
    exp_inst("t4_after", 32'h2000_0008, 32'h2000_0008);
    inst_ready = 1'b1;
    tick();
    exp_inst("t4_after_hi", 32'h2000_000C, 32'h2000_000C);
    tick();
    chk("t4_drained", inst_valid, 1'b0);

    // 5: stream with inst_ready toggling every cycle
    exp_pc = 32'h8000_0000;
    nxt    = 32'h8000_0000;
    for (int c = 0; c < 48; c++) begin
      inst_ready = c[0];
      offer(nxt);
      if (inst_valid && inst_ready) begin
        chk("t5_pc", inst_pc, exp_pc);
        chk("t5_data", inst_data, exp_pc);
        exp_pc = exp_pc + 32'd4;
      end
      acc = fetch_ready;
      tick();
      if (acc) nxt = nxt + 32'd8;
    end
    fetch_valid = 1'b0;
    inst_ready  = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (inst_valid) begin
        chk("t5_drain_pc", inst_pc, exp_pc);
        exp_pc = exp_pc + 32'd4;
      end
      tick();
    end
    chk("t5_all_delivered", exp_pc, nxt);
    chk("t5_progress", (nxt - 32'h8000_0000) >= 32'd64, 1'b1);
    chk("t5_empty", inst_valid, 1'b0);

    // 6: asynchronous reset between edges
    inst_ready = 1'b0;
    offer(32'h9000_0000);
    tick();
    offer(32'h9000_0008);
    tick();
    fetch_valid = 1'b0;
    chk("t6_pre_count", count, 2'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_valid", inst_valid, 1'b0);
    chk("t6_fready", fetch_ready, 1'b1);
    chk("t6_count", count, 2'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("t6_restart", count, 2'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
